// File: rtl/alu_issue_queue.sv
// Issue/capture front end for the 8-bit combinational ALU with a result FIFO.
// Optional popped-result statistics are enabled with `define ALU_ISSUE_QUEUE_STATS_EN.
module alu_issue_queue #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [SEL_W-1:0]         in_op,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [SEL_W-1:0]         alu_sel,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic                     out_zero,
    output logic                     out_illegal,
`ifdef ALU_ISSUE_QUEUE_STATS_EN
    output logic [15:0]              op_count,
    output logic [15:0]              illegal_count,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SEL_W-1:0] ILLEGAL_MIN = SEL_W'(5);
    localparam logic [CNT_W:0]   DEPTH_LIM   = (CNT_W + 1)'(DEPTH);

    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic [CNT_W:0]      load_s;

    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
    logic                iss_v_q, iss_v_d;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    occ_q, occ_d;
    logic [DATA_W-1:0]   res_mem_q [DEPTH];
    logic [DATA_W-1:0]   res_mem_d [DEPTH];
    logic                zero_mem_q [DEPTH];
    logic                zero_mem_d [DEPTH];
    logic                ill_mem_q [DEPTH];
    logic                ill_mem_d [DEPTH];

    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_result_q, out_result_d;
    logic                out_zero_q, out_zero_d;
    logic                out_illegal_q, out_illegal_d;

    // Issue stage: load ALU operand registers on accept, otherwise hold them.
    always_comb begin
        accept_s  = in_valid && in_ready_q;
        iss_v_d   = accept_s;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        if (accept_s) begin
            alu_a_d   = in_a;
            alu_b_d   = in_b;
            alu_sel_d = in_op;
        end else begin
            alu_a_d   = alu_a_q;
            alu_b_d   = alu_b_q;
            alu_sel_d = alu_sel_q;
        end
    end

    // Result FIFO: capture the ALU output the cycle after issue, pop on handshake.
    always_comb begin
        push_s     = iss_v_q;
        pop_s      = out_valid_q && out_ready;
        res_mem_d  = res_mem_q;
        zero_mem_d = zero_mem_q;
        ill_mem_d  = ill_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_s) begin
            res_mem_d[wr_ptr_q]  = alu_result;
            zero_mem_d[wr_ptr_q] = (alu_result == {DATA_W{1'b0}});
            ill_mem_d[wr_ptr_q]  = (alu_sel_q >= ILLEGAL_MIN);
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Next-state output view, so every output port comes straight from a flop.
    always_comb begin
        load_s        = {1'b0, occ_d} + {{CNT_W{1'b0}}, iss_v_d};
        in_ready_d    = (load_s < DEPTH_LIM);
        out_valid_d   = (occ_d != {CNT_W{1'b0}});
        out_result_d  = res_mem_d[rd_ptr_d];
        out_zero_d    = zero_mem_d[rd_ptr_d];
        out_illegal_d = ill_mem_d[rd_ptr_d];
    end

    // State register for issue stage, FIFO and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q       <= {DATA_W{1'b0}};
            alu_b_q       <= {DATA_W{1'b0}};
            alu_sel_q     <= {SEL_W{1'b0}};
            iss_v_q       <= 1'b0;
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            occ_q         <= {CNT_W{1'b0}};
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_result_q  <= {DATA_W{1'b0}};
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                res_mem_q[i]  <= {DATA_W{1'b0}};
                zero_mem_q[i] <= 1'b0;
                ill_mem_q[i]  <= 1'b0;
            end
        end else begin
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            iss_v_q       <= iss_v_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_illegal_q <= out_illegal_d;
            res_mem_q     <= res_mem_d;
            zero_mem_q    <= zero_mem_d;
            ill_mem_q     <= ill_mem_d;
        end
    end

`ifdef ALU_ISSUE_QUEUE_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] illegal_count_q, illegal_count_d;

    // Saturating counters of popped results and popped illegal-op results.
    always_comb begin
        op_count_d      = op_count_q;
        illegal_count_d = illegal_count_q;
        if (pop_s && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end else begin
            op_count_d = op_count_q;
        end
        if (pop_s && out_illegal_q && (illegal_count_q != 16'hFFFF)) begin
            illegal_count_d = illegal_count_q + 16'd1;
        end else begin
            illegal_count_d = illegal_count_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q      <= 16'd0;
            illegal_count_q <= 16'd0;
        end else begin
            op_count_q      <= op_count_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign op_count      = op_count_q;
    assign illegal_count = illegal_count_q;
`endif

    assign in_ready    = in_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_illegal = out_illegal_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus random traffic
// compared against a queue-based reference model; includes a behavioural ALU.
module tb_alu_issue_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic [2:0] in_op = 3'b000;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_illegal;
    logic [2:0] occupancy;
`ifdef ALU_ISSUE_QUEUE_STATS_EN
    logic [15:0] op_count;
    logic [15:0] illegal_count;
`endif

    alu_issue_queue #(.DATA_W(8), .SEL_W(3), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal),
`ifdef ALU_ISSUE_QUEUE_STATS_EN
        .op_count(op_count), .illegal_count(illegal_count),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return ~a;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_sel);

    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       ill;
    } ent_t;

    ent_t       mq[$];
    ent_t       m_iss;
    bit         m_iss_v;
    logic [7:0] m_alu_a, m_alu_b;
    logic [2:0] m_alu_sel;
    int         m_ops, m_ills;
    int         accepts;
    int         checks = 0;
    int         errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_iss_v   = 1'b0;
        m_alu_a   = 8'h00;
        m_alu_b   = 8'h00;
        m_alu_sel = 3'b000;
        m_ops     = 0;
        m_ills    = 0;
    endtask

    task automatic check_all();
        check_eq("in_ready", in_ready, (mq.size() + m_iss_v) < 4);
        check_eq("out_valid", out_valid, mq.size() != 0);
        check_eq("occupancy", occupancy, mq.size());
        check_eq("alu_a", alu_a, m_alu_a);
        check_eq("alu_b", alu_b, m_alu_b);
        check_eq("alu_sel", alu_sel, m_alu_sel);
        if (mq.size() != 0) begin
            check_eq("head_res", out_result, mq[0].r);
            check_eq("head_zero", out_zero, mq[0].z);
            check_eq("head_ill", out_illegal, mq[0].ill);
        end
`ifdef ALU_ISSUE_QUEUE_STATS_EN
        check_eq("op_count", op_count, m_ops);
        check_eq("illegal_count", illegal_count, m_ills);
`endif
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input bit ordy);
        bit   acc;
        logic [7:0] r;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        acc = v && ((mq.size() + m_iss_v) < 4);
        @(posedge clk);
        if (ordy && mq.size() != 0) begin
            m_ops++;
            if (mq[0].ill) m_ills++;
            void'(mq.pop_front());
        end
        if (m_iss_v) mq.push_back(m_iss);
        m_iss_v = acc;
        if (acc) begin
            accepts++;
            r         = alu_fn(a, b, op);
            m_iss     = '{r: r, z: (r == 8'h00), ill: (op >= 3'd5)};
            m_alu_a   = a;
            m_alu_b   = b;
            m_alu_sel = op;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_occupancy", occupancy, 3'd0);
        check_eq("rst_alu_sel", alu_sel, 3'b000);
        check_eq("rst_alu_a", alu_a, 8'h00);
        check_eq("rst_out_result", out_result, 8'h00);
        model_reset();
        rst_n = 1'b1;
    endtask

    logic [7:0] wrap_a  [4] = '{8'hFF, 8'h10, 8'hAA, 8'h12};
    logic [7:0] wrap_b  [4] = '{8'h01, 8'h10, 8'h00, 8'h00};
    logic [2:0] wrap_op [4] = '{3'b000, 3'b001, 3'b100, 3'b110};
    logic [7:0] wrap_r  [4] = '{8'h00, 8'h00, 8'h55, 8'h00};
    logic       wrap_z  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       wrap_i  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int idx;
        logic [7:0] held;
        model_reset();
        accepts = 0;
        do_reset();
        repeat (3) cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        check_eq("post_rst_idle", out_valid, 1'b0);

        // Single operation latency.
        cycle(1'b1, 8'h3C, 8'h05, 3'b000, 1'b0);
        check_eq("single_alu_a", alu_a, 8'h3C);
        check_eq("single_sel", alu_sel, 3'b000);
        check_eq("single_not_yet", out_valid, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        check_eq("single_valid", out_valid, 1'b1);
        check_eq("single_res", out_result, 8'h41);
        check_eq("single_zero", out_zero, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);

        // Wrap-around, zero and illegal flags, one result per cycle.
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) cycle(1'b1, wrap_a[i], wrap_b[i], wrap_op[i], 1'b1);
            else       cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
            if (out_valid && idx < 4) begin
                check_eq("wrap_res", out_result, wrap_r[idx]);
                check_eq("wrap_zero", out_zero, wrap_z[idx]);
                check_eq("wrap_ill", out_illegal, wrap_i[idx]);
                idx++;
            end
        end
        check_eq("wrap_count", idx, 4);

        // Backpressure: exactly DEPTH accepts, head stays put, then drain.
        accepts = 0;
        cycle(1'b1, 8'h01, 8'h01, 3'b000, 1'b0);
        held = 8'h02;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'h10 + 8'(i), 8'h01, 3'b000, 1'b0);
            if (out_valid) check_eq("bp_head_stable", out_result, held);
        end
        check_eq("bp_accepts", accepts, 4);
        check_eq("bp_occ_sat", occupancy, 3'd4);
        check_eq("bp_in_ready", in_ready, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        check_eq("bp_full_pop_ready", in_ready, 1'b1);
        repeat (5) cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        check_eq("bp_drained", occupancy, 3'd0);

        // Simultaneous push and pop at occupancy 2.
        repeat (3) cycle(1'b1, 8'h20, 8'h03, 3'b001, 1'b0);
        check_eq("pp_occ_before", occupancy, 3'd2);
        cycle(1'b1, 8'h0F, 8'hF0, 3'b011, 1'b1);
        check_eq("pp_occ_after", occupancy, 3'd2);
        repeat (5) cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 5));
        end
        repeat (6) cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);

        // Mid-stream reset with occupancy 3 and an issue in flight.
        do_reset();
        repeat (4) cycle(1'b1, 8'h44, 8'h11, 3'b010, 1'b0);
        check_eq("mid_occ3", occupancy, 3'd3);
        check_eq("mid_full", in_ready, 1'b0);
        do_reset();
        repeat (2) cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        check_eq("mid_no_out", out_valid, 1'b0);
        cycle(1'b1, 8'h01, 8'h02, 3'b011, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        check_eq("mid_first_valid", out_valid, 1'b1);
        check_eq("mid_first_res", out_result, 8'h03);
        cycle(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
`ifdef ALU_ISSUE_QUEUE_STATS_EN
        check_eq("mid_op_count", op_count, 16'd1);
`endif
        check_eq("mid_empty", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
